mic1_exec_ctrl: RTL

Execution controller for the MIC-1 core on the FPGA board. It turns one-cycle button event pulses from the debounced button front end into MIC-1 clock-enable and reset controls, supporting run, stop, multi-cycle single-step, CPU-requested halt and a stretched synchronous CPU reset. It also drives the status LEDs and keeps an enabled-cycle counter for debug readout.

---
 rtl/mic1_exec_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mic1_exec_ctrl.sv
// mic1_exec_ctrl
//
// Execution controller for the MIC-1 core. It turns one-cycle button event
// pulses into MIC-1 clock-enable and reset controls. Supported modes are
// run, stop, multi-cycle single-step, CPU-requested halt and a stretched
// synchronous CPU reset. It also drives the status LEDs and keeps a
// saturating count of enabled cycles for debug readout.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high block reset
//   btn_pulse    one-cycle events: [0] run, [1] ignored, [2] step,
//                [3] stop, [4] cpu reset request
//   cpu_halt     MIC-1 halt level, synchronous to clk
//   cpu_ce       MIC-1 clock enable (high in RUN and STEP)
//   cpu_rst      MIC-1 synchronous reset (high in RESET)
//   led          [0] RUN, [1] STOP, [2] STEP, [3] HALT, [4] RESET,
//                [5] heartbeat = cycle_count[HB_BIT]
//   cycle_count  cpu_ce-high cycles since the last cpu reset, saturating

module mic1_exec_ctrl #(
   parameter int STEP_CYCLES      = 1,
   parameter int RST_PULSE_CYCLES = 4,
   parameter int CNT_W            = 32,
   parameter int HB_BIT           = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       btn_pulse,
   input  logic             cpu_halt,
   output logic             cpu_ce,
   output logic             cpu_rst,
   output logic [5:0]       led,
   output logic [CNT_W-1:0] cycle_count
);

   // One down-counter serves both the reset stretch and the step length;
   // the two are never active at the same time.
   localparam int MAX_CYC = (STEP_CYCLES > RST_PULSE_CYCLES) ? STEP_CYCLES : RST_PULSE_CYCLES;
   localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CTR_W-1:0] RST_LOAD  = CTR_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CTR_W-1:0] STEP_LOAD = CTR_W'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RESET,
      S_STOP,
      S_RUN,
      S_STEP,
      S_HALT
   } state_t;

   state_t           state_reg, state_next;
   logic [CTR_W-1:0] ctr_reg, ctr_next;
   logic [CNT_W-1:0] count_reg;

   logic ev_run, ev_step, ev_stop, ev_cpurst;
   logic unused_btn;

   assign ev_run     = btn_pulse[0];
   assign ev_step    = btn_pulse[2];
   assign ev_stop    = btn_pulse[3];
   assign ev_cpurst  = btn_pulse[4];
   assign unused_btn = btn_pulse[1];

   // Next-state logic. The cpu reset request is applied last, so it
   // overrides every other event in every state.
   always_comb begin
      state_next = state_reg;
      ctr_next   = ctr_reg;
      case (state_reg)
         S_RESET: begin
            if (ctr_reg == '0) state_next = S_STOP;
            else               ctr_next   = ctr_reg - 1'b1;
         end
         S_STOP: begin
            if (ev_stop) begin
               state_next = S_STOP;
            end else if (ev_step) begin
               state_next = S_STEP;
               ctr_next   = STEP_LOAD;
            end else if (ev_run) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (ev_stop)       state_next = S_STOP;
            else if (cpu_halt) state_next = S_HALT;
         end
         S_STEP: begin
            if (ev_stop)              state_next = S_STOP;
            else if (cpu_halt)        state_next = S_HALT;
            else if (ctr_reg == '0)   state_next = S_STOP;
            else                      ctr_next   = ctr_reg - 1'b1;
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_RESET;
            ctr_next   = RST_LOAD;
         end
      endcase
      if (ev_cpurst) begin
         state_next = S_RESET;
         ctr_next   = RST_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_RESET;
         ctr_reg   <= RST_LOAD;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         ctr_reg   <= ctr_next;
         // Count follows the current (registered) enable, so the cycle in
         // which an event is sampled still counts if the core was enabled.
         if (state_reg == S_RESET)
            count_reg <= '0;
         else if (cpu_ce && (count_reg != {CNT_W{1'b1}}))
            count_reg <= count_reg + 1'b1;
      end
   end

   assign cpu_ce      = (state_reg == S_RUN) || (state_reg == S_STEP);
   assign cpu_rst     = (state_reg == S_RESET);
   assign cycle_count = count_reg;

   assign led[0] = (state_reg == S_RUN);
   assign led[1] = (state_reg == S_STOP);
   assign led[2] = (state_reg == S_STEP);
   assign led[3] = (state_reg == S_HALT);
   assign led[4] = (state_reg == S_RESET);
   assign led[5] = count_reg[HB_BIT];

endmodule
